// File: rtl/vga_timing_controller.sv
// VGA raster scanner: pixel-rate divider, x/y counters, and a registered connector
// stage that keeps colour, syncs and blank aligned to the same pixel.
module vga_timing_controller #(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_color,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_END   = 10'(H_SYNC);
  localparam logic [9:0] VS_END   = 10'(V_SYNC);
  localparam logic [9:0] HA_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HA_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] VA_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VA_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             vga_clk_q, vga_clk_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             pix_en, line_end, frame_end, active;

  always_comb begin
    pix_en    = (div_cnt_q == DIV_LAST);
    line_end  = (x_q == X_LAST);
    frame_end = line_end && (y_q == Y_LAST);
    active    = (x_q >= HA_START) && (x_q < HA_END) &&
                (y_q >= VA_START) && (y_q < VA_END);

    div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_ONE;
    // Second half of each pixel drives vga_clk high so its rising edge lands mid-pixel.
    vga_clk_d = (div_cnt_d >= DIV_HALF);

    x_d       = x_q;
    y_d       = y_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;

    if (pix_en) begin
      if (line_end) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      // Connector stage uses the pre-increment coordinate, so it lags x/y by one pixel.
      hs_d      = !(x_q < HS_END);
      vs_d      = !(y_q < VS_END);
      blank_n_d = active;
      rgb_d     = active ? rgb_color : 24'h000000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      vga_clk_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vga_clk_q <= vga_clk_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign vga_clk     = vga_clk_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign frame_start = pix_en && frame_end;

endmodule
